// File: rtl/spc_counter_if.sv
// ---------------------------------------------------------------------------
// spc_counter_if
// Bundles the single-photon counter's detector, gate, window-select and
// result signals so that the counter and its driver share one connection.
//
// Parameters:
//   SEL_W  width of the history window-select
//   CNT_W  width of the photon count / SPC data word
//
// Signals:
//   i_photon      asynchronous detector TTL pulse
//   i_gate        count gate (synchronous to the system clock)
//   i_window_sel  history index, 0 = most recent window
//   o_spc_data    registered count of the selected window
//   o_window_done one-cycle pulse when a window count is pushed to history
//   o_counting    high while a window is being counted
//
// Modports:
//   master  drives the inputs and observes the results (parser side)
//   slave   the counter itself
// ---------------------------------------------------------------------------
interface spc_counter_if #(
  parameter int SEL_W = 1,
  parameter int CNT_W = 16
);
  logic             i_photon;
  logic             i_gate;
  logic [SEL_W-1:0] i_window_sel;
  logic [CNT_W-1:0] o_spc_data;
  logic             o_window_done;
  logic             o_counting;

  modport master (
    output i_photon,
    output i_gate,
    output i_window_sel,
    input  o_spc_data,
    input  o_window_done,
    input  o_counting
  );

  modport slave (
    input  i_photon,
    input  i_gate,
    input  i_window_sel,
    output o_spc_data,
    output o_window_done,
    output o_counting
  );
endinterface

// File: rtl/spc_counter.sv
// ---------------------------------------------------------------------------
// spc_counter
// Single-photon counter front end for the sequencer's instruction parser.
// Counts rising edges of the asynchronous detector pulse while the gate is
// high, pushes each finished window's count into a history shift register and
// presents the selected window's count as registered SPC data.
//
// Ports:
//   sys_clock  system clock, all logic on the rising edge
//   i_reset_n  synchronous, active-low reset
//   bus        spc_counter_if.slave (photon, gate, window select, results)
//
// Parameters:
//   DEPTH  number of stored count windows (>= 1)
//   SEL_W  window-select width (2**SEL_W >= DEPTH)
//   CNT_W  count width
//
// Build option:
//   SPC_SATURATE_EN  when defined the window counter saturates at all-ones;
//                    otherwise it wraps modulo 2**CNT_W.
// ---------------------------------------------------------------------------
module spc_counter #(
  parameter int DEPTH = 2,
  parameter int SEL_W = 1,
  parameter int CNT_W = 16
) (
  input  logic          sys_clock,
  input  logic          i_reset_n,
  spc_counter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, edge_q;
  logic             photon_edge_s;
  logic [SEL_W-1:0] sel_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hist_q [DEPTH];
  logic [CNT_W-1:0] hist_d [DEPTH];
  logic [CNT_W-1:0] spc_data_q, spc_data_d;
  logic             done_q, done_d;

  // One cycle after the second synchronizer stage rises, edge_q catches up,
  // so the edge pulse lasts exactly one cycle per detector pulse.
  assign photon_edge_s = sync2_q & ~edge_q;
  assign sel_s         = bus.i_window_sel;

  // Photon synchronizer and edge-detect flops.
  always_ff @(posedge sys_clock) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= bus.i_photon;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // Window state machine: counting, push to history, done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hist_d  = hist_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_gate) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = COUNT;
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (bus.i_gate) begin
          if (photon_edge_s) begin
`ifdef SPC_SATURATE_EN
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              cnt_d = cnt_q;
            end
`else
            cnt_d = cnt_q + CNT_W'(1);
`endif
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          // Gate fell: an edge arriving in this same cycle is not counted.
          hist_d[0] = cnt_q;
          for (int k = 1; k < DEPTH; k++) begin
            hist_d[k] = hist_q[k-1];
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output select: out-of-range indices read as zero.
  always_comb begin
    spc_data_d = {CNT_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      spc_data_d = (int'(sel_s) == k) ? hist_q[k] : spc_data_d;
    end
  end

  // State, counter, history and output registers.
  always_ff @(posedge sys_clock) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      spc_data_q <= {CNT_W{1'b0}};
      done_q     <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= {CNT_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      spc_data_q <= spc_data_d;
      done_q     <= done_d;
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= hist_d[k];
      end
    end
  end

  assign bus.o_spc_data    = spc_data_q;
  assign bus.o_window_done = done_q;
  assign bus.o_counting    = (state_q == COUNT);

endmodule

// File: tb/tb_spc_counter.sv
// ---------------------------------------------------------------------------
// tb_spc_counter
// Directed, table-driven bench for spc_counter. The main instance uses
// DEPTH=2, SEL_W=2, CNT_W=16. A second instance with CNT_W=2 reaches the
// counter's all-ones boundary in a few pulses: after 2 edges it sits at the
// equivalent of 16'hFFFE, and 3 more edges give wrap -> 1 or saturate -> 3.
// ---------------------------------------------------------------------------
module tb_spc_counter;

  logic       sys_clock = 1'b0;
  logic       i_reset_n;
  logic       photon_s, gate_s, use_b_s;
  logic [1:0] sel_s;

  int n_pass  = 0;
  int n_total = 0;
  int done_a  = 0;
  int done_b  = 0;

  always #5 sys_clock = ~sys_clock;

  spc_counter_if #(.SEL_W(2), .CNT_W(16)) bus   ();
  spc_counter_if #(.SEL_W(1), .CNT_W(2))  bus_b ();

  assign bus.i_photon       = use_b_s ? 1'b0 : photon_s;
  assign bus.i_gate         = use_b_s ? 1'b0 : gate_s;
  assign bus.i_window_sel   = sel_s;
  assign bus_b.i_photon     = use_b_s ? photon_s : 1'b0;
  assign bus_b.i_gate       = use_b_s ? gate_s : 1'b0;
  assign bus_b.i_window_sel = 1'b0;

  spc_counter #(.DEPTH(2), .SEL_W(2), .CNT_W(16)) dut (
    .sys_clock (sys_clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  spc_counter #(.DEPTH(2), .SEL_W(1), .CNT_W(2)) dut_b (
    .sys_clock (sys_clock),
    .i_reset_n (i_reset_n),
    .bus       (bus_b)
  );

  // Independent count of done pulses seen on each instance.
  always @(negedge sys_clock) begin
    if (bus.o_window_done)   done_a <= done_a + 1;
    if (bus_b.o_window_done) done_b <= done_b + 1;
  end

  typedef struct {
    int          pulses;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clock);
      #1;
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      photon_s = 1'b1;
      cyc(3);
      photon_s = 1'b0;
      cyc(3);
    end
  endtask

  // Returns one cycle after the gate-low edge, i.e. on the done cycle.
  task automatic window(input int n);
    gate_s = 1'b1;
    cyc(2);
    pulses(n);
    cyc(2);
    gate_s = 1'b0;
    cyc(1);
  endtask

  initial begin
    int          exp_done;
    int          d;
    logic [15:0] v;
    logic [1:0]  exp_b;

    vecs[0] = '{7, 16'd7, 16'd0};
    vecs[1] = '{5, 16'd5, 16'd7};
    vecs[2] = '{9, 16'd9, 16'd5};
    vecs[3] = '{2, 16'd2, 16'd9};
    exp_done = 0;

    i_reset_n = 1'b0;
    photon_s  = 1'b0;
    gate_s    = 1'b0;
    sel_s     = 2'd0;
    use_b_s   = 1'b0;
    cyc(3);
    chk("rst_data",     bus.o_spc_data,    32'd0);
    chk("rst_done",     bus.o_window_done, 32'd0);
    chk("rst_counting", bus.o_counting,    32'd0);
    chk("rst_data_b",   bus_b.o_spc_data,  32'd0);
    i_reset_n = 1'b1;
    cyc(1);

    // Table: successive windows, history shift, out-of-range select.
    for (int i = 0; i < 4; i++) begin
      window(vecs[i].pulses);
      chk("done_pulse", bus.o_window_done, 32'd1);
      chk("idle_after_push", bus.o_counting, 32'd0);
      cyc(1);
      chk("done_single", bus.o_window_done, 32'd0);
      chk("data_sel0", bus.o_spc_data, vecs[i].exp0);
      sel_s = 2'd1;
      cyc(1);
      chk("data_sel1", bus.o_spc_data, vecs[i].exp1);
      sel_s = 2'd3;
      cyc(1);
      chk("data_sel3", bus.o_spc_data, 32'd0);
      sel_s = 2'd0;
      cyc(1);
      exp_done++;
      chk("done_count", done_a, exp_done);
    end

    // Pulses while IDLE are ignored; a 1-cycle gate pushes 0.
    pulses(3);
    cyc(4);
    gate_s = 1'b1;
    cyc(1);
    chk("short_counting", bus.o_counting, 32'd1);
    gate_s = 1'b0;
    cyc(1);
    chk("short_done", bus.o_window_done, 32'd1);
    cyc(1);
    chk("short_sel0", bus.o_spc_data, 32'd0);
    sel_s = 2'd1;
    cyc(1);
    chk("short_sel1", bus.o_spc_data, 32'd2);
    sel_s = 2'd0;

    // Edge landing on the gate-falling cycle is not counted.
    gate_s = 1'b1;
    cyc(2);
    pulses(1);
    photon_s = 1'b1;
    cyc(2);
    gate_s = 1'b0;
    cyc(1);
    chk("fall_done", bus.o_window_done, 32'd1);
    photon_s = 1'b0;
    cyc(1);
    chk("fall_edge_dropped", bus.o_spc_data, 32'd1);
    cyc(3);

    // Back-to-back windows with a single low gate cycle between them.
    gate_s = 1'b1;
    cyc(2);
    pulses(1);
    cyc(2);
    gate_s = 1'b0;
    cyc(1);
    chk("b2b_done1", bus.o_window_done, 32'd1);
    chk("b2b_idle", bus.o_counting, 32'd0);
    gate_s = 1'b1;
    cyc(1);
    chk("b2b_counting", bus.o_counting, 32'd1);
    chk("b2b_data1", bus.o_spc_data, 32'd1);
    pulses(2);
    cyc(2);
    gate_s = 1'b0;
    cyc(1);
    chk("b2b_done2", bus.o_window_done, 32'd1);
    cyc(1);
    chk("b2b_sel0", bus.o_spc_data, 32'd2);
    sel_s = 2'd1;
    cyc(1);
    chk("b2b_sel1", bus.o_spc_data, 32'd1);
    sel_s = 2'd0;

    // A 1-cycle glitch may or may not be counted.
    gate_s = 1'b1;
    cyc(2);
    pulses(2);
    photon_s = 1'b1;
    cyc(1);
    photon_s = 1'b0;
    cyc(5);
    gate_s = 1'b0;
    cyc(2);
    v = bus.o_spc_data;
    chk("glitch_2_or_3", 32'((v == 16'd2) || (v == 16'd3)), 32'd1);

    // Reset in the middle of a window discards the count.
    gate_s = 1'b1;
    cyc(2);
    pulses(4);
    chk("pre_rst_counting", bus.o_counting, 32'd1);
    d = done_a;
    i_reset_n = 1'b0;
    gate_s    = 1'b0;
    cyc(1);
    chk("mid_rst_counting", bus.o_counting, 32'd0);
    chk("mid_rst_done", bus.o_window_done, 32'd0);
    chk("mid_rst_data", bus.o_spc_data, 32'd0);
    i_reset_n = 1'b1;
    cyc(1);
    sel_s = 2'd1;
    cyc(1);
    chk("mid_rst_hist1", bus.o_spc_data, 32'd0);
    sel_s = 2'd0;
    cyc(1);
    chk("mid_rst_hist0", bus.o_spc_data, 32'd0);
    chk("mid_rst_no_push", done_a, d);
    window(3);
    chk("post_rst_done", bus.o_window_done, 32'd1);
    cyc(1);
    chk("post_rst_sel0", bus.o_spc_data, 32'd3);
    sel_s = 2'd1;
    cyc(1);
    chk("post_rst_sel1", bus.o_spc_data, 32'd0);
    sel_s = 2'd0;

    // Counter boundary on the narrow instance: 5 edges from 0.
`ifdef SPC_SATURATE_EN
    exp_b = 2'd3;
`else
    exp_b = 2'd1;
`endif
    use_b_s = 1'b1;
    window(5);
    chk("bound_done", bus_b.o_window_done, 32'd1);
    cyc(1);
    chk("bound_count", bus_b.o_spc_data, 32'(exp_b));
    chk("bound_done_count", done_b, 32'd1);
    use_b_s = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spc_counter.md
Name: spc_counter

Overview:
- Single-photon counter (SPC) front end feeding the sequencer's instruction parser.
- Counts rising edges of an asynchronous detector pulse input while a gate channel from the parser's output bus is high.
- Stores each completed gate window's count in a history shift register.
- Presents the selected window's count as 16-bit SPC data, used by the parser for threshold jumps.

Parameters:
- DEPTH, 2, number of stored count windows (history entries); minimum 1
- SEL_W, 1, width of the window-select input; 2**SEL_W >= DEPTH
- CNT_W, 16, count width; must match the parser's SPC data width

Ports:
- sys_clock  input  1  100 MHz system clock; all logic on rising edge
- i_reset_n  input  1  synchronous, active-low reset
- i_photon  input  1  asynchronous detector TTL pulse
- i_gate  input  1  count gate, driven from one output-bus channel
- i_window_sel  input  SEL_W  history index: 0 = most recent window, 1 = previous, ...
- o_spc_data  output  CNT_W  count of the selected window, registered
- o_window_done  output  1  one-cycle pulse when a window's count is pushed to history
- o_counting  output  1  high while state == COUNT

Behaviour:
- Clock and reset: one clock, sys_clock. Reset is synchronous, active-low, on i_reset_n.
- Reset (i_reset_n == 0 at a rising edge) sets:
  - state to IDLE
  - counter to 0
  - all history entries to 0
  - o_spc_data to 0
  - o_window_done to 0
  - o_counting to 0
  - synchronizer and edge flops to 0
- Reset mid-window discards the running count; nothing is pushed.
- Photon path:
  - 2-flop synchronizer on i_photon, then one edge-detect flop.
  - photon_edge = sync2 & !edge_q.
  - photon_edge asserts 3 cycles after an i_photon rise.
  - i_photon high and low times must each be >= 2 clock periods (20 ns). Shorter pulses may be missed; this is not flagged.
- i_gate is synchronous to sys_clock and is used without a synchronizer.
- State machine, IDLE:
  - o_counting = 0.
  - If i_gate == 1: counter <= 0, go to COUNT.
  - photon_edge is ignored in IDLE.
- State machine, COUNT:
  - o_counting = 1.
  - If i_gate == 1 and photon_edge: counter <= counter + 1 (overflow rule under Optional Feature).
  - If i_gate == 0, in the same cycle:
    - history[0] <= counter (the edge in this cycle is not counted)
    - history[k] <= history[k-1] for k = 1..DEPTH-1; the oldest entry is dropped
    - o_window_done <= 1 for exactly one cycle
    - go to IDLE
- Gate high for 1 cycle gives a pushed count of 0.
- Back-to-back windows (gate low for 1 cycle between highs): the push and IDLE take 1 cycle, and the next COUNT starts on the following cycle. No window is lost.
- Output:
  - o_spc_data <= history[i_window_sel] every cycle (1-cycle registered latency).
  - Returns 0 if i_window_sel >= DEPTH.
  - After a push, o_spc_data shows the new count one cycle after o_window_done rises.
- History holds its values indefinitely while IDLE; only reset or a new push changes it.

Optional Feature:
- Macro: SPC_SATURATE_EN
- Defined: counter saturates at 2**CNT_W-1 (16'hFFFF); further edges are ignored until the next window starts.
- Not defined: counter wraps modulo 2**CNT_W (16'hFFFF + 1 -> 16'h0000).
- Everything else is identical with or without the macro.

Test Plan:
- Reset, then gate high 100 cycles with 7 clean photon pulses (each 3 high / 3 low) all inside the window, gate low -> one o_window_done pulse; with sel = 0, o_spc_data = 7 one cycle later.
- Two windows with 5 then 9 pulses -> sel = 0 gives 9, sel = 1 gives 5; a third window with 2 pulses -> sel = 0 gives 2, sel = 1 gives 9; 5 is dropped (DEPTH = 2).
- Pulses outside the gate (IDLE) plus a 1-cycle gate -> pushed count 0; a pulse whose photon_edge falls on the gate-falling cycle is not counted.
- Force counter to 16'hFFFE, then 3 edges -> with SPC_SATURATE_EN the result is 16'hFFFF; without the macro it is 16'h0001.
- Assert i_reset_n = 0 mid-window after 4 counts -> no o_window_done, all history = 0, o_counting = 0; a next window with 3 pulses gives 3.
- i_window_sel = 3 with SEL_W = 2, DEPTH = 2 -> o_spc_data = 0; a 1-cycle photon glitch -> count unchanged or +1, and the bench accepts either value.
